fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32; this is the PC and instruction width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4; this is the prefetch FIFO entry count, a power of two and at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 0; this is the PC loaded at reset.
REQ-004 The block SHALL have parameter STEP, default 4; this is the PC increment per fetched instruction.
REQ-005 The block SHALL have port _clk, input, width 1; it is the single clock, and all state updates on its rising edge.
REQ-006 The block SHALL have port _reset, input, width 1; it is a synchronous, active-low reset.
REQ-007 The block SHALL have port _redirect, input, width 1; it requests a PC load (branch or jump).
REQ-008 The block SHALL have port _redirectPc, input, width WIDTH; it is the target PC for a redirect.
REQ-009 The block SHALL have port _memReq, output, width 1; it is the instruction-memory read strobe.
REQ-010 The block SHALL have port _memAddr, output, width WIDTH; it is the read address and equals the current fetch PC.
REQ-011 The block SHALL have port _memRdata, input, width WIDTH; it is the read data, valid exactly one cycle after _memReq.
REQ-012 The block SHALL have port _outValid, output, width 1; it is high when the FIFO head holds an instruction.
REQ-013 The block SHALL have port _outReady, input, width 1; it is the decode-stage accept signal.
REQ-014 The block SHALL have port _outInstr, output, width WIDTH; it is the FIFO head instruction.
REQ-015 The block SHALL have port _outPc, output, width WIDTH; it is the FIFO head instruction address.
REQ-016 The block SHALL have port _outPcNext, output, width WIDTH; it is _outPc+STEP, modulo 2^WIDTH.

Function
REQ-017 The block SHALL compute the issue condition as _memReq = !_redirect && (fifoCount + inflight < DEPTH); fifoCount is the registered value and gets no pop lookahead.
REQ-018 On each issue, the fetch PC SHALL advance by STEP at the clock edge, wrapping modulo 2^WIDTH.
REQ-019 The block SHALL hold one inflight bit per cycle: it is set when _memReq is issued and cleared the next cycle.
REQ-020 On an inflight cycle, the block SHALL push {_memRdata, issued PC} into the FIFO, unless the entry is killed.
REQ-021 Latency SHALL be two cycles: a request at cycle t gives _outValid at cycle t+2, with no bypass path.
REQ-022 A pop SHALL occur when _outValid && _outReady; _outInstr/_outPc SHALL hold stable while _outValid && !_outReady.
REQ-023 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-024 FIFO full (count==DEPTH) SHALL block issue; a push to a full FIFO SHALL be impossible by construction.
REQ-025 FIFO empty SHALL drive _outValid=0; _outInstr/_outPc are then don't-care.
REQ-026 On _redirect=1, the block SHALL load the fetch PC from _redirectPc, clear the FIFO, and mark any inflight response as killed (not pushed).
REQ-027 _redirect together with a pop SHALL let the redirect win: the FIFO becomes empty and the pop has no further effect.
REQ-028 After a redirect at cycle t, the first request SHALL be at t+1 with _memAddr=_redirectPc.
REQ-029 Back-to-back redirects SHALL each take effect, with the last one determining the PC.
REQ-030 FIFO read/write pointers SHALL wrap modulo DEPTH, and count SHALL range over 0..DEPTH.

Reset
REQ-031 With _reset=0 at a rising edge, the block SHALL set fetch PC=RESET_PC, FIFO count=0, pointers=0, inflight=0, and kill=0.
REQ-032 The reset values of the outputs SHALL be: _outValid=0, _memAddr=RESET_PC, and _memReq=0 while _reset=0.
REQ-033 Reset SHALL dominate _redirect and any inflight response (e.g. reset mid-fetch), dropping all data.
REQ-034 The first request SHALL occur in the first cycle with _reset=1.

Configuration
REQ-035 The macro FETCH_UNIT_PERF_COUNT_EN, when defined, SHALL add output _perfCount (32 bits), which counts accepted outputs (_outValid && _outReady).
REQ-036 _perfCount SHALL reset to 0, wrap at 2^32, and not be cleared by _redirect.
REQ-037 Without FETCH_UNIT_PERF_COUNT_EN, the _perfCount port and its counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Reset then release with _outReady=1 and memory returning addr+0x100 -> _memAddr 0,4,8,… one per cycle; first _outValid at cycle 2 with _outInstr=0x100, _outPc=0, _outPcNext=4.
REQ-039 Hold _outReady=0 with DEPTH=4 -> exactly 4 requests (0,4,8,C), then _memReq=0; _outPc stays 0; on release, outputs 0,4,8,C come in order with no loss or duplicate.
REQ-040 Assert _redirect with _redirectPc=0x40 while the FIFO holds 2 and a request is inflight -> the next cycle has _outValid=0 and _memAddr=0x40; the first output is _outPc=0x40, and the killed data never appears.
REQ-041 Assert _redirect and _outReady together with the FIFO non-empty -> the FIFO empties and _perfCount does not increment for that cycle.
REQ-042 Set fetch PC=0xFFFFFFFC with STEP=4 -> the next _memAddr=0x0 and _outPcNext=0x0.
REQ-043 Assert _reset=0 for one cycle mid-stream with an inflight request -> _outValid=0 next cycle, fetch restarts at RESET_PC, and _perfCount=0 (with the macro defined).

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencer, single-outstanding-response tracking and a prefetch FIFO.
// Optional build macro FETCH_UNIT_PERF_COUNT_EN adds the _perfCount accepted-output counter.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] STEP     = WIDTH'(4)
) (
    input  logic             _clk,
    input  logic             _reset,
    input  logic             _redirect,
    input  logic [WIDTH-1:0] _redirectPc,
    output logic             _memReq,
    output logic [WIDTH-1:0] _memAddr,
    input  logic [WIDTH-1:0] _memRdata,
    output logic             _outValid,
    input  logic             _outReady,
    output logic [WIDTH-1:0] _outInstr,
    output logic [WIDTH-1:0] _outPc,
    output logic [WIDTH-1:0] _outPcNext
`ifdef FETCH_UNIT_PERF_COUNT_EN
    ,
    output logic [31:0]      _perfCount
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] fetch_pc;
    logic             inflight;
    logic [WIDTH-1:0] inflight_pc;
    logic             kill;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [WIDTH-1:0] mem_pc    [DEPTH];

    // Occupancy reserves a slot for the response in flight, so a push can never hit a full FIFO.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign issue     = _reset && !_redirect && (occupancy < (CNT_W + 1)'(DEPTH));
    assign push      = inflight && !kill && !_redirect;
    assign pop       = _outValid && _outReady;

    assign _memReq   = issue;
    assign _memAddr  = fetch_pc;
    assign _outValid = (count != '0);
    assign _outInstr = mem_instr[rd_ptr];
    assign _outPc    = mem_pc[rd_ptr];
    assign _outPcNext = mem_pc[rd_ptr] + STEP;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge _clk) begin
        if (!_reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            kill        <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (_redirect) begin
            // Redirect beats any same-cycle push or pop; the FIFO restarts empty.
            fetch_pc    <= _redirectPc;
            inflight    <= 1'b0;
            kill        <= 1'b1;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            kill     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + STEP;
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; entries are only visible once count says they were written.
    always_ff @(posedge _clk) begin
        if (_reset && push) begin
            mem_instr[wr_ptr] <= _memRdata;
            mem_pc[wr_ptr]    <= inflight_pc;
        end
    end

`ifdef FETCH_UNIT_PERF_COUNT_EN
    always_ff @(posedge _clk) begin
        if (!_reset) begin
            _perfCount <= '0;
        end else if (pop && !_redirect) begin
            _perfCount <= _perfCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory model returns addr+0x100 one cycle after a request.
// Perf-counter checks are compiled in when FETCH_UNIT_PERF_COUNT_EN is defined.
module tb_fetch_unit;

    logic        clk;
    logic        _reset;
    logic        _redirect;
    logic [31:0] _redirectPc;
    logic        _memReq;
    logic [31:0] _memAddr;
    logic [31:0] _memRdata;
    logic        _outValid;
    logic        _outReady;
    logic [31:0] _outInstr;
    logic [31:0] _outPc;
    logic [31:0] _outPcNext;
`ifdef FETCH_UNIT_PERF_COUNT_EN
    logic [31:0] _perfCount;
`endif

    int          total = 0;
    int          bad   = 0;
    logic        req_s;
    logic [31:0] addr_s;
    int          nreq;

    fetch_unit #(
        .WIDTH   (32),
        .DEPTH   (4),
        .RESET_PC(32'h0),
        .STEP    (32'h4)
    ) dut (
        ._clk       (clk),
        ._reset     (_reset),
        ._redirect  (_redirect),
        ._redirectPc(_redirectPc),
        ._memReq    (_memReq),
        ._memAddr   (_memAddr),
        ._memRdata  (_memRdata),
        ._outValid  (_outValid),
        ._outReady  (_outReady),
        ._outInstr  (_outInstr),
        ._outPc     (_outPc),
        ._outPcNext (_outPcNext)
`ifdef FETCH_UNIT_PERF_COUNT_EN
        ,
        ._perfCount (_perfCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; the memory answers the request seen just before the edge.
    task automatic tick();
        req_s  = _memReq;
        addr_s = _memAddr;
        @(posedge clk);
        #1;
        _memRdata = req_s ? addr_s + 32'h100 : 32'hDEAD_BEEF;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        _reset      = 1'b0;
        _redirect   = 1'b0;
        _redirectPc = 32'h0;
        _outReady   = 1'b1;
        _memRdata   = 32'h0;
        #1;
        check("rst_req_early", {31'b0, _memReq}, 32'h0);

        // Reset and streaming with ready held high
        tick();
        tick();
        settle();
        check("rst_valid", {31'b0, _outValid}, 32'h0);
        check("rst_addr", _memAddr, 32'h0);
        check("rst_req", {31'b0, _memReq}, 32'h0);
        _reset = 1'b1;
        settle();
        check("c0_req", {31'b0, _memReq}, 32'h1);
        check("c0_addr", _memAddr, 32'h0);
        check("c0_valid", {31'b0, _outValid}, 32'h0);
        tick(); settle();
        check("c1_addr", _memAddr, 32'h4);
        check("c1_valid", {31'b0, _outValid}, 32'h0);
        tick(); settle();
        check("c2_valid", {31'b0, _outValid}, 32'h1);
        check("c2_instr", _outInstr, 32'h100);
        check("c2_pc", _outPc, 32'h0);
        check("c2_next", _outPcNext, 32'h4);
        check("c2_addr", _memAddr, 32'h8);
        tick(); settle();
        check("c3_pc", _outPc, 32'h4);
        check("c3_addr", _memAddr, 32'hC);
`ifdef FETCH_UNIT_PERF_COUNT_EN
        check("c3_perf", _perfCount, 32'h1);
`endif

        // Redirect together with a pop: redirect wins, nothing counted
        _redirect   = 1'b1;
        _redirectPc = 32'h80;
        settle();
        check("rp_req", {31'b0, _memReq}, 32'h0);
        tick();
        _redirect = 1'b0;
        settle();
        check("rp_valid", {31'b0, _outValid}, 32'h0);
        check("rp_addr", _memAddr, 32'h80);
`ifdef FETCH_UNIT_PERF_COUNT_EN
        check("rp_perf", _perfCount, 32'h1);
`endif

        // Back-to-back redirects, the last one wins
        _redirect   = 1'b1;
        _redirectPc = 32'h200;
        settle();
        tick();
        _redirectPc = 32'h300;
        settle();
        tick();
        _redirect = 1'b0;
        settle();
        check("b2b_addr", _memAddr, 32'h300);
        check("b2b_valid", {31'b0, _outValid}, 32'h0);
        tick(); settle();
        tick(); settle();
        check("b2b_pc", _outPc, 32'h300);
        check("b2b_instr", _outInstr, 32'h400);

        // PC wrap at the top of the address space
        _redirect   = 1'b1;
        _redirectPc = 32'hFFFF_FFFC;
        settle();
        tick();
        _redirect = 1'b0;
        settle();
        check("wrap_addr0", _memAddr, 32'hFFFF_FFFC);
        tick(); settle();
        check("wrap_addr1", _memAddr, 32'h0);
        tick(); settle();
        check("wrap_pc", _outPc, 32'hFFFF_FFFC);
        check("wrap_next", _outPcNext, 32'h0);
        check("wrap_instr", _outInstr, 32'h0000_00FC);

        // One-cycle reset mid-stream with a response in flight
        _reset = 1'b0;
        settle();
        check("mr_req_in_rst", {31'b0, _memReq}, 32'h0);
        tick();
        _reset = 1'b1;
        settle();
        check("mr_valid", {31'b0, _outValid}, 32'h0);
        check("mr_addr", _memAddr, 32'h0);
        check("mr_req", {31'b0, _memReq}, 32'h1);
`ifdef FETCH_UNIT_PERF_COUNT_EN
        check("mr_perf", _perfCount, 32'h0);
`endif
        tick(); settle();
        tick(); settle();
        check("mr_pc", _outPc, 32'h0);
        check("mr_instr", _outInstr, 32'h100);

        // Backpressure: exactly DEPTH requests, head held, then in-order drain
        _reset    = 1'b0;
        _outReady = 1'b0;
        tick();
        _reset = 1'b1;
        settle();
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            if (_memReq) nreq++;
            if (i >= 4) check($sformatf("bp_idle%0d", i), {31'b0, _memReq}, 32'h0);
            if (i >= 2) check($sformatf("bp_hold%0d", i), _outPc, 32'h0);
            tick(); settle();
        end
        check("bp_nreq", nreq, 32'd4);
        _outReady = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_pc%0d", k), _outPc, 32'(4 * k));
            check($sformatf("bp_instr%0d", k), _outInstr, 32'(4 * k + 32'h100));
            tick(); settle();
        end

        // Redirect with two entries queued and one response in flight
        _reset    = 1'b0;
        _outReady = 1'b0;
        tick();
        _reset = 1'b1;
        settle();
        tick(); settle();
        tick(); settle();
        tick(); settle();
        check("k_pre_pc", _outPc, 32'h0);
        _redirect   = 1'b1;
        _redirectPc = 32'h40;
        settle();
        check("k_req", {31'b0, _memReq}, 32'h0);
        tick();
        _redirect = 1'b0;
        _outReady = 1'b1;
        settle();
        check("k_valid", {31'b0, _outValid}, 32'h0);
        check("k_addr", _memAddr, 32'h40);
        tick(); settle();
        check("k_valid1", {31'b0, _outValid}, 32'h0);
        tick(); settle();
        check("k_pc", _outPc, 32'h40);
        check("k_instr", _outInstr, 32'h140);
        tick(); settle();
        check("k_pc2", _outPc, 32'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
